// File: rtl/pad_bank_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pad_bank_dir_ctrl
// Description : Direction sequencer for a bank of bidirectional pads that share
//               one direction. It enforces a break-before-make turnaround, so
//               output drive is never enabled while the input buffer is enabled
//               or during the dead time. It accepts one requester over a
//               valid/ready handshake and synchronizes the pad input data.
// Ports       : clk_i, rst_ni (asynchronous, active-low)
//               req_valid_i/req_ready_o/req_dir_i/req_ds_i/req_pe_i : request
//               release_i : abort toward input mode
//               ack_o     : one-cycle pulse when the requested mode is in effect
//               dir_o     : stable direction (0 during turnaround)
//               out_data_i/in_data_o : functional data to/from the SoC
//               pad_pe_o/pad_ie_o/pad_ds_o/pad_oen_o/pad_i_o : pad controls
//               pad_c_i   : pad input data (already gated by ie at the pad)
// Revision    : 1.0 - initial release
// ============================================================================
module pad_bank_dir_ctrl #(
    parameter int unsigned NumPads    = 8,
    parameter int unsigned TurnCycles = 2,
    parameter int unsigned SyncStages = 2,
    parameter logic        PullEnRst  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_dir_i,
    input  logic               req_ds_i,
    input  logic               req_pe_i,
    input  logic               release_i,
    output logic               ack_o,
    output logic               dir_o,
    input  logic [NumPads-1:0] out_data_i,
    output logic [NumPads-1:0] in_data_o,
    output logic [NumPads-1:0] pad_pe_o,
    output logic [NumPads-1:0] pad_ie_o,
    output logic [NumPads-1:0] pad_ds_o,
    output logic [NumPads-1:0] pad_oen_o,
    output logic [NumPads-1:0] pad_i_o,
    input  logic [NumPads-1:0] pad_c_i
);

    localparam int unsigned     CntW    = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(TurnCycles - 1);

    typedef enum logic [1:0] {
        ST_INPUT  = 2'd0,
        ST_TO_OUT = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_TO_IN  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pe_q, pe_d;
    logic            ds_q, ds_d;
    logic            ack_q, ack_d;
    // Set when the running turnaround was started by a request (and so owes
    // an ack on arrival); cleared for release-induced turnarounds.
    logic            ack_pend_q, ack_pend_d;
    logic            accept;
    logic            in_mode;
    logic            out_mode;

    assign in_mode     = (state_q == ST_INPUT);
    assign out_mode    = (state_q == ST_OUTPUT);
    assign req_ready_o = (in_mode || out_mode) && !release_i;
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INPUT;
            cnt_q      <= '0;
            pe_q       <= PullEnRst;
            ds_q       <= 1'b0;
            ack_q      <= 1'b0;
            ack_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pe_q       <= pe_d;
            ds_q       <= ds_d;
            ack_q      <= ack_d;
            ack_pend_q <= ack_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pe_d       = pe_q;
        ds_d       = ds_q;
        ack_d      = 1'b0;
        ack_pend_d = ack_pend_q;
        if (accept) begin
            pe_d = req_pe_i;
            ds_d = req_ds_i;
        end
        case (state_q)
            ST_INPUT: begin
                if (accept) begin
                    if (req_dir_i) begin
                        state_d    = ST_TO_OUT;
                        cnt_d      = CntLoad;
                        ack_pend_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            ST_OUTPUT: begin
                if (release_i) begin
                    state_d    = ST_TO_IN;
                    cnt_d      = CntLoad;
                    ack_pend_d = 1'b0;
                end else if (accept) begin
                    if (!req_dir_i) begin
                        state_d    = ST_TO_IN;
                        cnt_d      = CntLoad;
                        ack_pend_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            ST_TO_OUT: begin
                // Release wins even on the final dead cycle: never reach OUTPUT.
                if (release_i) begin
                    state_d    = ST_TO_IN;
                    cnt_d      = CntLoad;
                    ack_pend_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d    = ST_OUTPUT;
                    ack_d      = ack_pend_q;
                    ack_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TO_IN: begin
                if (cnt_q == '0) begin
                    state_d    = ST_INPUT;
                    ack_d      = ack_pend_q;
                    ack_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_INPUT;
                cnt_d   = '0;
            end
        endcase
    end

    // Pad controls depend only on registered state/config (pad_i_o additionally
    // passes out_data_i through while driving).
    assign pad_oen_o = {NumPads{!out_mode}};
    assign pad_ie_o  = {NumPads{in_mode}};
    assign pad_pe_o  = {NumPads{in_mode && pe_q}};
    assign pad_ds_o  = {NumPads{out_mode && ds_q}};
    assign pad_i_o   = out_data_i & {NumPads{out_mode}};
    assign dir_o     = out_mode;
    assign ack_o     = ack_q;

    // Input synchronizer: free-running front stages, final stage frozen
    // outside INPUT so in_data_o holds the last value seen in input mode.
    logic [NumPads-1:0] last_src;
    logic [NumPads-1:0] in_q;

    generate
        if (SyncStages > 1) begin : g_front
            logic [NumPads-1:0] front_q [SyncStages-1];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < int'(SyncStages) - 1; i++) begin
                        front_q[i] <= '0;
                    end
                end else begin
                    front_q[0] <= pad_c_i;
                    for (int i = 1; i < int'(SyncStages) - 1; i++) begin
                        front_q[i] <= front_q[i-1];
                    end
                end
            end
            assign last_src = front_q[SyncStages-2];
        end else begin : g_direct
            assign last_src = pad_c_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_q <= '0;
        end else if (in_mode) begin
            in_q <= last_src;
        end
    end

    assign in_data_o = in_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_bank_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_bank_dir_ctrl
// Description : Self-checking bench for pad_bank_dir_ctrl. A timeline-based
//               reference model (settle cycle numbers, delay queue) predicts
//               every output each cycle under directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_bank_dir_ctrl;

    localparam int   N   = 8;
    localparam int   TC  = 2;
    localparam int   SS  = 2;
    localparam logic PER = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_dir, req_ds, req_pe, rel;
    logic         req_ready, ack, dir;
    logic [N-1:0] out_data, pad_raw, in_data;
    logic [N-1:0] pad_pe, pad_ie, pad_ds, pad_oen, pad_i;
    logic [N-1:0] pad_c;

    always #5 clk = ~clk;

    // The pad itself gates its receiver output with ie.
    assign pad_c = pad_raw & pad_ie;

    pad_bank_dir_ctrl #(
        .NumPads   (N),
        .TurnCycles(TC),
        .SyncStages(SS),
        .PullEnRst (PER)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_dir_i  (req_dir),
        .req_ds_i   (req_ds),
        .req_pe_i   (req_pe),
        .release_i  (rel),
        .ack_o      (ack),
        .dir_o      (dir),
        .out_data_i (out_data),
        .in_data_o  (in_data),
        .pad_pe_o   (pad_pe),
        .pad_ie_o   (pad_ie),
        .pad_ds_o   (pad_ds),
        .pad_oen_o  (pad_oen),
        .pad_i_o    (pad_i),
        .pad_c_i    (pad_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a settled direction plus, while turning, the cycle at
    // which the target direction takes effect.
    int           cyc;
    bit           m_dir, m_turning, m_target, m_ack_on;
    int           m_end, m_ack_cyc;
    bit           m_pe, m_ds;
    logic [N-1:0] m_in;
    logic [N-1:0] sq[$];
    bit           prev_ie, prev_drv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        cyc       = 0;
        m_dir     = 1'b0;
        m_turning = 1'b0;
        m_target  = 1'b0;
        m_ack_on  = 1'b0;
        m_end     = -1;
        m_ack_cyc = -1;
        m_pe      = PER;
        m_ds      = 1'b0;
        m_in      = '0;
        sq.delete();
        for (int i = 0; i < SS - 1; i++) sq.push_back('0);
        prev_ie   = 1'b1;
        prev_drv  = 1'b0;
    endtask

    task automatic model_edge();
        bit           was_in;
        logic [N-1:0] samp;
        int           e;
        was_in = !m_turning && !m_dir;
        samp   = was_in ? pad_raw : '0;
        if (was_in) m_in = (SS == 1) ? samp : sq[0];
        sq.push_back(samp);
        if (sq.size() > SS - 1) void'(sq.pop_front());
        e = cyc + 1;
        if (m_turning) begin
            if (rel && m_target) begin
                m_target = 1'b0;
                m_end    = e + TC;
                m_ack_on = 1'b0;
            end
        end else if (rel) begin
            if (m_dir) begin
                m_turning = 1'b1;
                m_target  = 1'b0;
                m_end     = e + TC;
                m_ack_on  = 1'b0;
            end
        end else if (req_valid) begin
            m_pe = req_pe;
            m_ds = req_ds;
            if (req_dir == m_dir) begin
                m_ack_cyc = e;
            end else begin
                m_turning = 1'b1;
                m_target  = req_dir;
                m_end     = e + TC;
                m_ack_on  = 1'b1;
            end
        end
        cyc = e;
        if (m_turning && cyc == m_end) begin
            m_turning = 1'b0;
            m_dir     = m_target;
            if (m_ack_on) m_ack_cyc = cyc;
        end
    endtask

    task automatic check_all();
        bit           o, i;
        logic [N-1:0] all1;
        all1 = '1;
        o = !m_turning && m_dir;
        i = !m_turning && !m_dir;
        check_eq("oen",     pad_oen,   o ? 32'd0 : 32'(all1));
        check_eq("ie",      pad_ie,    i ? 32'(all1) : 32'd0);
        check_eq("pe",      pad_pe,    (i && m_pe) ? 32'(all1) : 32'd0);
        check_eq("ds",      pad_ds,    (o && m_ds) ? 32'(all1) : 32'd0);
        check_eq("pad_i",   pad_i,     o ? 32'(out_data) : 32'd0);
        check_eq("dir",     dir,       o);
        check_eq("ready",   req_ready, !m_turning && !rel);
        check_eq("ack",     ack,       m_ack_cyc == cyc);
        check_eq("in_data", in_data,   m_in);
        check_eq("excl",    |(~pad_oen & pad_ie), 0);
        check_eq("bbm",     (prev_ie && !(&pad_oen)) || (prev_drv && (|pad_ie)), 0);
        prev_ie  = |pad_ie;
        prev_drv = !(&pad_oen);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #2;
        check_all();
    endtask

    task automatic set_req(input bit v, input bit d, input bit ds, input bit pe);
        req_valid = v;
        req_dir   = d;
        req_ds    = ds;
        req_pe    = pe;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all();
        check_eq("rst_oen", pad_oen, 32'hFF);
        check_eq("rst_pe",  pad_pe,  32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        rel      = 1'b0;
        out_data = '0;
        pad_raw  = '0;
        set_req(0, 0, 0, 0);
        model_reset();
        #1;
        do_reset();

        // Input -> output, ds=1, drive 0xA5.
        out_data = 8'hA5;
        set_req(1, 1, 1, 1);
        cycle();
        check_eq("to_out_ie", pad_ie, 32'd0);
        set_req(0, 0, 0, 0);
        cycle();
        cycle();
        check_eq("out_pad_i", pad_i, 32'hA5);
        check_eq("out_ack",   ack,   1);
        cycle();
        check_eq("ack_once",  ack,   0);

        // Output -> input with pe=0; 0x3C appears SyncStages cycles after entry.
        pad_raw = 8'h3C;
        set_req(1, 0, 0, 0);
        cycle();
        set_req(0, 0, 0, 0);
        repeat (2) cycle();
        check_eq("in_entry_pe", pad_pe, 32'd0);
        repeat (SS) cycle();
        check_eq("in_data_3c", in_data, 32'h3C);

        // Same-direction request in INPUT: no dead cycles.
        set_req(1, 0, 0, 1);
        cycle();
        set_req(0, 0, 0, 0);
        check_eq("same_ack", ack,    1);
        check_eq("same_pe",  pad_pe, 32'hFF);

        // Release mid TO_OUT: back to input, no ack, valid ignored while busy.
        set_req(1, 1, 1, 0);
        cycle();
        rel = 1'b1;
        cycle();
        rel = 1'b0;
        set_req(1, 1, 0, 0);
        cycle();
        set_req(0, 0, 0, 0);
        cycle();
        check_eq("rel_no_ack", ack,    0);
        check_eq("rel_ie",     pad_ie, 32'hFF);

        // Into OUTPUT, then asynchronous reset mid-cycle.
        set_req(1, 1, 1, 1);
        cycle();
        set_req(0, 0, 0, 0);
        repeat (TC) cycle();
        check_eq("pre_rst_oen", pad_oen, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_oen", pad_oen, 32'hFF);
        check_eq("arst_ie",  pad_ie,  32'hFF);
        check_eq("arst_pe",  pad_pe,  32'hFF);
        do_reset();

        // Random request stream.
        for (int k = 0; k < 400; k++) begin
            set_req(($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            rel      = ($urandom_range(0, 7) == 0);
            out_data = N'($urandom);
            pad_raw  = N'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
